oled_page_writer: RTL and testbench
===================================

// Module: oled_page_writer
// PURPOSE
//  Streams a page-addressed framebuffer (default 128x64 mono = 8 pages x 128 cols) to the OLED
//  through the single-byte i2c_master. For each page: three commands (page, col low, col high),
//  then COLS data bytes read from an external 1-cycle-latency framebuffer RAM.
//  Upstream of the I2C mux in oled_ctrl; same start/done, reg_addr/reg_data/i2c_write_en/i2c_done contract as oled_disp.
// PARAMETERS
//  PAGES      8      pages per frame (8 rows of pixels each)
//  COLS       128    columns per page
//  COL_OFFSET 0      column start offset (2 for SH1106 panels)
//  AW         10     framebuffer address width, >= clog2(PAGES*COLS)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  start         in   1   1-cycle pulse: begin frame refresh; ignored while busy
//  busy          out  1   high from cycle after accepted start until done
//  done          out  1   1-cycle pulse at frame end
//  fb_rd_en      out  1   framebuffer read strobe
//  fb_addr       out  AW  read address = page*COLS + col
//  fb_rdata      in   8   read data, valid the cycle after fb_rd_en
//  reg_addr      out  8   I2C control byte: 8'h00 command, 8'h40 data
//  reg_data      out  8   I2C payload byte
//  i2c_write_en  out  1   1-cycle pulse: launch one I2C write
//  i2c_done      in   1   1-cycle pulse: current I2C write finished
//  dirty_mark    in   1   (OLED_PAGE_WRITER_DIRTY_EN only) mark dirty_page as modified
//  dirty_page    in   3   (OLED_PAGE_WRITER_DIRTY_EN only) page index, clog2(PAGES) bits
// BEHAVIOUR
//  Reset: state IDLE; busy, done, fb_rd_en, i2c_write_en = 0; reg_addr, reg_data, fb_addr = 0; page, col, cmd counters = 0.
//  Reset mid-frame aborts immediately; no resume. i2c_done pulses in the cycle after reset are ignored.
//  FSM: IDLE -> PAGE_SEL -> CMD_ISSUE <-> CMD_WAIT (x3) -> FETCH -> LATCH -> DAT_ISSUE -> DAT_WAIT
//   -> FETCH (next col) | PAGE_SEL (next page) | FINISH -> IDLE.
//  Commands per page, reg_addr=8'h00: 8'hB0|page; 8'h00|COL_OFFSET[3:0]; 8'h10|COL_OFFSET[7:4].
//  FETCH: fb_rd_en=1 for 1 cycle, fb_addr=page*COLS+col. LATCH: reg_data<=fb_rdata, reg_addr<=8'h40.
//  *_ISSUE: i2c_write_en=1 for exactly 1 cycle; reg_addr/reg_data are set on ISSUE entry and held until i2c_done.
//  *_WAIT: stay until i2c_done; no timeout. i2c_done seen outside *_WAIT is ignored.
//  Last col of a page (col==COLS-1) acked -> col=0, page+1. Last page acked -> FINISH: done=1 one cycle, busy=0 the next cycle.
//  Per-page cost: 3 commands + COLS data writes; at most one I2C write outstanding.
//  start in same cycle as reset: reset wins. start while busy: dropped, not queued.
// CONFIGURATION
//  OLED_PAGE_WRITER_DIRTY_EN defined: PAGES-bit dirty register, all bits set at reset; dirty_mark sets bit.
//   PAGE_SEL skips clean pages, selecting the lowest dirty page >= current page. Bit clears when the page's last data byte is acked;
//   dirty_mark on the same page in that cycle wins (bit stays set). start with no dirty page:
//   busy 1 cycle, done pulse, no i2c_write_en.
//  Undefined: dirty ports absent; every start writes all PAGES pages.
// STRUCTURE
//  oled_pkg: control bytes OLED_CTRL_CMD=8'h00, OLED_CTRL_DATA=8'h40; opcodes OLED_CMD_PAGE=8'hB0,
//   OLED_CMD_COLL=8'h00, OLED_CMD_COLH=8'h10; FSM state localparams.
//  Sub-module oled_page_dirty (dirty register + lowest-set-bit priority select), instantiated only under the macro.
// TESTING
//  1 start, i2c_done 3 cycles after each write_en -> exactly 8*(3+128)=1048 write_en pulses, single done pulse, busy low after.
//  2 page 2 start -> writes 00/B2, 00/00, 00/10, then 40/fb[256..383] in order; fb_addr 256 on first data fetch.
//  3 COL_OFFSET=2 -> col commands 00/02 and 00/10 on every page.
//  4 reset asserted during page 3 data -> next cycle all outputs 0, busy 0; new start restarts at page 0 with B0.
//  5 start pulses during busy and stray i2c_done in IDLE -> no extra writes, no second done.
//  6 DIRTY_EN: after one full refresh, mark pages 1 and 6, start -> only B1 and B6 sequences (262 writes);
//   start with none dirty -> done pulse, zero writes.

Source files
------------

// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oled_pkg
//  Description : Shared constants, FSM state encoding and command-byte helper
//                for the OLED page writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package oled_pkg;

   // I2C control bytes that precede every payload byte
   localparam logic [7:0] OLED_CTRL_CMD  = 8'h00;
   localparam logic [7:0] OLED_CTRL_DATA = 8'h40;

   // Addressing opcodes; the low nibble carries the operand
   localparam logic [7:0] OLED_CMD_PAGE  = 8'hB0;
   localparam logic [7:0] OLED_CMD_COLL  = 8'h00;
   localparam logic [7:0] OLED_CMD_COLH  = 8'h10;

   // Number of addressing commands sent ahead of each page's data
   localparam logic [1:0] OLED_CMDS_PER_PAGE = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PAGE_SEL  = 4'd1,
      ST_CMD_ISSUE = 4'd2,
      ST_CMD_WAIT  = 4'd3,
      ST_FETCH     = 4'd4,
      ST_LATCH     = 4'd5,
      ST_DAT_ISSUE = 4'd6,
      ST_DAT_WAIT  = 4'd7,
      ST_FINISH    = 4'd8
   } state_e;

   // Command byte for step idx of a page header: page select, column low nibble, column high nibble
   function automatic logic [7:0] oled_cmd_byte(input logic [1:0] idx,
                                                input logic [3:0] page,
                                                input logic [7:0] col_off);
      logic [7:0] b;
      case (idx)
         2'd0:    b = OLED_CMD_PAGE | {4'h0, page};
         2'd1:    b = OLED_CMD_COLL | {4'h0, col_off[3:0]};
         default: b = OLED_CMD_COLH | {4'h0, col_off[7:4]};
      endcase
      return b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/oled_page_dirty.sv
`default_nettype none
// ============================================================================
//  Module      : oled_page_dirty
//  Description : Per-page dirty flags plus a priority select returning the
//                lowest dirty page at or above a starting page. Used only when
//                OLED_PAGE_WRITER_DIRTY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_page_dirty
   import oled_pkg::*;
#(
   parameter int PAGES = 8,
   parameter int PW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          mark,
   input  logic [PW-1:0] mark_page,
   input  logic          clear,
   input  logic [PW-1:0] clear_page,
   input  logic [PW-1:0] from_page,
   output logic          found,
   output logic [PW-1:0] sel_page
);

   logic [PAGES-1:0] dirty_q;
   logic [PAGES-1:0] dirty_d;

   // Clear first so a mark to the same page in the same cycle keeps the bit set
   always_comb begin
      dirty_d = dirty_q;
      if (clear) dirty_d[clear_page] = 1'b0;
      if (mark)  dirty_d[mark_page]  = 1'b1;
   end

   // Downward scan leaves the lowest qualifying index as the winner
   always_comb begin
      found    = 1'b0;
      sel_page = '0;
      for (int i = PAGES - 1; i >= 0; i--) begin
         if (dirty_q[i] && (i >= int'(from_page))) begin
            found    = 1'b1;
            sel_page = PW'(i);
         end
      end
   end

   // Every page starts dirty so the first refresh after reset paints the whole panel
   always_ff @(posedge clk) begin
      if (reset) dirty_q <= '1;
      else       dirty_q <= dirty_d;
   end

endmodule
`default_nettype wire

// File: rtl/oled_page_writer.sv
`default_nettype none
// ============================================================================
//  Module      : oled_page_writer
//  Description : Streams a page-addressed mono framebuffer to an OLED through
//                a single-byte I2C master: three addressing commands per page,
//                then COLS data bytes fetched from a 1-cycle-latency RAM.
//                Optional macro OLED_PAGE_WRITER_DIRTY_EN: only pages marked
//                dirty are written.
//  Revision    : 1.0 - initial release
// ============================================================================
module oled_page_writer
   import oled_pkg::*;
#(
   parameter int PAGES      = 8,
   parameter int COLS       = 128,
   parameter int COL_OFFSET = 0,
   parameter int AW         = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     fb_rd_en,
   output logic [AW-1:0]            fb_addr,
   input  logic [7:0]               fb_rdata,
   output logic [7:0]               reg_addr,
   output logic [7:0]               reg_data,
   output logic                     i2c_write_en,
`ifdef OLED_PAGE_WRITER_DIRTY_EN
   input  logic                     dirty_mark,
   input  logic [$clog2(PAGES)-1:0] dirty_page,
`endif
   input  logic                     i2c_done
);

   localparam int             PW        = $clog2(PAGES);
   localparam int             CW        = $clog2(COLS);
   localparam logic [7:0]     COL_OFF_B = 8'(COL_OFFSET);
   localparam logic [PW-1:0]  PAGE_LAST = PW'(PAGES - 1);
   localparam logic [CW-1:0]  COL_LAST  = CW'(COLS - 1);

   state_e          state_q,    state_d;
   logic [PW-1:0]   page_q,     page_d;
   logic [CW-1:0]   col_q,      col_d;
   logic [1:0]      cmd_q,      cmd_d;
   logic [7:0]      reg_addr_q, reg_addr_d;
   logic [7:0]      reg_data_q, reg_data_d;
   logic [AW-1:0]   fb_addr_q,  fb_addr_d;

   logic            sel_found;
   logic [PW-1:0]   sel_page;

   function automatic logic [AW-1:0] addr_of(input logic [PW-1:0] p, input logic [CW-1:0] c);
      return AW'(p) * AW'(COLS) + AW'(c);
   endfunction

`ifdef OLED_PAGE_WRITER_DIRTY_EN
   logic page_last_ack;

   // A page becomes clean once its final data byte has been acknowledged
   assign page_last_ack = (state_q == ST_DAT_WAIT) && i2c_done && (col_q == COL_LAST);

   oled_page_dirty #(
      .PAGES (PAGES),
      .PW    (PW)
   ) u_dirty (
      .clk        (clk),
      .reset      (reset),
      .mark       (dirty_mark),
      .mark_page  (dirty_page),
      .clear      (page_last_ack),
      .clear_page (page_q),
      .from_page  (page_q),
      .found      (sel_found),
      .sel_page   (sel_page)
   );
`else
   // Without dirty tracking every page is always selected in order
   assign sel_found = 1'b1;
   assign sel_page  = page_q;
`endif

   // Next-state and strobe decode; strobes are pure functions of the current state
   always_comb begin
      state_d      = state_q;
      page_d       = page_q;
      col_d        = col_q;
      cmd_d        = cmd_q;
      reg_addr_d   = reg_addr_q;
      reg_data_d   = reg_data_q;
      fb_addr_d    = fb_addr_q;
      busy         = (state_q != ST_IDLE);
      done         = 1'b0;
      fb_rd_en     = 1'b0;
      i2c_write_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               page_d  = '0;
               col_d   = '0;
               cmd_d   = '0;
               state_d = ST_PAGE_SEL;
            end
         end
         ST_PAGE_SEL: begin
            if (sel_found) begin
               page_d     = sel_page;
               cmd_d      = '0;
               reg_addr_d = OLED_CTRL_CMD;
               reg_data_d = oled_cmd_byte(2'd0, 4'(sel_page), COL_OFF_B);
               state_d    = ST_CMD_ISSUE;
            end else begin
               // Nothing left to write: finish straight from here
               done    = 1'b1;
               page_d  = '0;
               state_d = ST_IDLE;
            end
         end
         ST_CMD_ISSUE: begin
            i2c_write_en = 1'b1;
            state_d      = ST_CMD_WAIT;
         end
         ST_CMD_WAIT: begin
            if (i2c_done) begin
               if (cmd_q == OLED_CMDS_PER_PAGE - 2'd1) begin
                  cmd_d     = '0;
                  col_d     = '0;
                  fb_addr_d = addr_of(page_q, '0);
                  state_d   = ST_FETCH;
               end else begin
                  cmd_d      = cmd_q + 2'd1;
                  reg_data_d = oled_cmd_byte(cmd_q + 2'd1, 4'(page_q), COL_OFF_B);
                  state_d    = ST_CMD_ISSUE;
               end
            end
         end
         ST_FETCH: begin
            fb_rd_en = 1'b1;
            state_d  = ST_LATCH;
         end
         ST_LATCH: begin
            reg_addr_d = OLED_CTRL_DATA;
            reg_data_d = fb_rdata;
            state_d    = ST_DAT_ISSUE;
         end
         ST_DAT_ISSUE: begin
            i2c_write_en = 1'b1;
            state_d      = ST_DAT_WAIT;
         end
         ST_DAT_WAIT: begin
            if (i2c_done) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (page_q == PAGE_LAST) begin
                     state_d = ST_FINISH;
                  end else begin
                     page_d  = page_q + PW'(1);
                     state_d = ST_PAGE_SEL;
                  end
               end else begin
                  col_d     = col_q + CW'(1);
                  fb_addr_d = addr_of(page_q, col_q + CW'(1));
                  state_d   = ST_FETCH;
               end
            end
         end
         ST_FINISH: begin
            done    = 1'b1;
            page_d  = '0;
            col_d   = '0;
            cmd_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any frame in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         page_q     <= '0;
         col_q      <= '0;
         cmd_q      <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         fb_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         page_q     <= page_d;
         col_q      <= col_d;
         cmd_q      <= cmd_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         fb_addr_q  <= fb_addr_d;
      end
   end

   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign fb_addr  = fb_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_oled_page_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oled_page_writer
//  Description : Self-checking bench for oled_page_writer. Two instances run
//                in lockstep (column offset 0 and 2) against a framebuffer
//                RAM model, an I2C responder with random latency and a
//                frame-level reference model of the expected write stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oled_page_writer;

   localparam int PAGES = 8;
   localparam int COLS  = 128;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          reset, start;
   logic          resp_done, stray_done;
   logic          i2c_done;
   assign i2c_done = resp_done | stray_done;

   logic          busy_a, done_a, rd_a, we_a;
   logic [AW-1:0] addr_a;
   logic [7:0]    rdata_a, ra_a, rdat_a;
   logic          busy_b, done_b, rd_b, we_b;
   logic [AW-1:0] addr_b;
   logic [7:0]    rdata_b, ra_b, rdat_b;
`ifdef OLED_PAGE_WRITER_DIRTY_EN
   logic          dirty_mark;
   logic [2:0]    dirty_page;
`endif

   always #5 clk = ~clk;

   oled_page_writer #(.PAGES(PAGES), .COLS(COLS), .COL_OFFSET(0), .AW(AW)) u_a (
      .clk(clk), .reset(reset), .start(start), .busy(busy_a), .done(done_a),
      .fb_rd_en(rd_a), .fb_addr(addr_a), .fb_rdata(rdata_a),
      .reg_addr(ra_a), .reg_data(rdat_a), .i2c_write_en(we_a),
`ifdef OLED_PAGE_WRITER_DIRTY_EN
      .dirty_mark(dirty_mark), .dirty_page(dirty_page),
`endif
      .i2c_done(i2c_done));

   oled_page_writer #(.PAGES(PAGES), .COLS(COLS), .COL_OFFSET(2), .AW(AW)) u_b (
      .clk(clk), .reset(reset), .start(start), .busy(busy_b), .done(done_b),
      .fb_rd_en(rd_b), .fb_addr(addr_b), .fb_rdata(rdata_b),
      .reg_addr(ra_b), .reg_data(rdat_b), .i2c_write_en(we_b),
`ifdef OLED_PAGE_WRITER_DIRTY_EN
      .dirty_mark(dirty_mark), .dirty_page(dirty_page),
`endif
      .i2c_done(i2c_done));

   // Framebuffer contents and 1-cycle-latency read ports
   logic [7:0] fb [0:PAGES*COLS-1];
   always @(posedge clk) begin
      if (rd_a) rdata_a <= fb[addr_a];
      if (rd_b) rdata_b <= fb[addr_b];
   end

   // I2C responder: one done pulse lat cycles after each write strobe
   int lat_lo = 3, lat_hi = 3;
   initial begin
      int cnt;
      cnt = 0;
      resp_done = 1'b0;
      forever begin
         @(negedge clk);
         resp_done = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) resp_done = 1'b1;
         end
         if (we_a) cnt = (lat_lo == lat_hi) ? lat_lo : int'($urandom_range(lat_hi, lat_lo));
      end
   end

   // Capture of observed traffic
   logic [15:0] wq_a[$], wq_b[$], fq[$];
   logic [15:0] exp_a[$], exp_b[$], exp_f[$];
   int          done_cnt;
   always @(negedge clk) begin
      if (we_a)   wq_a.push_back({ra_a, rdat_a});
      if (we_b)   wq_b.push_back({ra_b, rdat_b});
      if (rd_a)   fq.push_back(16'(addr_a));
      if (done_a) done_cnt++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cmp_q(input string name, input logic [15:0] got[$], input logic [15:0] exp[$]);
      int m, bad;
      logic [15:0] gv, ev;
      m   = (got.size() < exp.size()) ? got.size() : exp.size();
      bad = (got.size() != exp.size()) ? m : -1;
      for (int i = 0; i < m; i++) begin
         if (got[i] !== exp[i]) begin
            bad = i;
            break;
         end
      end
      checks++;
      if (bad >= 0) begin
         errors++;
         gv = (bad < got.size()) ? got[bad] : 16'hxxxx;
         ev = (bad < exp.size()) ? exp[bad] : 16'hxxxx;
         $display("FAIL %s index %0d actual=%h required=%h (sizes %0d/%0d)",
                  name, bad, gv, ev, got.size(), exp.size());
      end
   endtask

   // Reference dirty state (all pages dirty after reset)
   logic [7:0] dirty_m;

   task automatic mark_pages(input logic [7:0] mask);
`ifdef OLED_PAGE_WRITER_DIRTY_EN
      for (int p = 0; p < PAGES; p++) begin
         if (mask[p]) begin
            dirty_mark = 1'b1;
            dirty_page = 3'(p);
            @(negedge clk);
         end
      end
      dirty_mark = 1'b0;
      dirty_m    = dirty_m | mask;
`else
      dirty_m    = dirty_m | mask;
`endif
   endtask

   // Expected write streams for one frame, from the page list and framebuffer
   task automatic build_expected();
      int pages[$];
      int a;
      exp_a.delete(); exp_b.delete(); exp_f.delete();
      for (int p = 0; p < PAGES; p++) begin
`ifdef OLED_PAGE_WRITER_DIRTY_EN
         if (dirty_m[p]) pages.push_back(p);
`else
         pages.push_back(p);
`endif
      end
      dirty_m = 8'h00;
      foreach (pages[i]) begin
         exp_a.push_back({8'h00, 8'(8'hB0 + pages[i])});
         exp_a.push_back({8'h00, 8'(8'h00 + (0 % 16))});
         exp_a.push_back({8'h00, 8'(8'h10 + (0 / 16))});
         exp_b.push_back({8'h00, 8'(8'hB0 + pages[i])});
         exp_b.push_back({8'h00, 8'(8'h00 + (2 % 16))});
         exp_b.push_back({8'h00, 8'(8'h10 + (2 / 16))});
         for (int c = 0; c < COLS; c++) begin
            a = pages[i] * COLS + c;
            exp_f.push_back(16'(a));
            exp_a.push_back({8'h40, fb[a]});
            exp_b.push_back({8'h40, fb[a]});
         end
      end
   endtask

   typedef struct {
      int         lat_lo;
      int         lat_hi;
      logic [7:0] mark;
      int         extra;
      int         exp_full;
      int         exp_dirty;
   } row_t;

   task automatic run_frame(input row_t r);
      bit seen;
      int n, extra, expn;
      mark_pages(r.mark);
      build_expected();
      wq_a.delete(); wq_b.delete(); fq.delete();
      done_cnt = 0;
      lat_lo   = r.lat_lo;
      lat_hi   = r.lat_hi;
`ifdef OLED_PAGE_WRITER_DIRTY_EN
      expn = r.exp_dirty;
`else
      expn = r.exp_full;
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy_a), 1);
      seen  = done_a;
      n     = 0;
      extra = 0;
      while (!seen && n < 40000) begin
         if (extra < r.extra && $urandom_range(0, 150) == 0) begin
            start = 1'b1;
            extra++;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
         seen = done_a;
      end
      start = 1'b0;
      chk("done_seen", 32'(seen), 1);
      @(negedge clk);
      chk("busy_after_done", 32'(busy_a), 0);
      repeat (30) @(negedge clk);
      chk("done_count", 32'(done_cnt), 1);
      chk("write_count", 32'(wq_a.size()), 32'(expn));
      cmp_q("stream_off0", wq_a, exp_a);
      cmp_q("stream_off2", wq_b, exp_b);
      cmp_q("fetch_addrs", fq, exp_f);
   endtask

   row_t rows[5];

   initial begin
      int n;
      rows[0] = '{3, 3, 8'hFF, 0, 1048, 1048};
      rows[1] = '{1, 4, 8'hFF, 3, 1048, 1048};
      rows[2] = '{1, 1, 8'h42, 1, 1048, 262};
      rows[3] = '{2, 2, 8'h00, 0, 1048, 0};
      rows[4] = '{1, 2, 8'h04, 0, 1048, 131};

      for (int i = 0; i < PAGES * COLS; i++) fb[i] = 8'($urandom);
      reset      = 1'b1;
      start      = 1'b0;
      stray_done = 1'b0;
`ifdef OLED_PAGE_WRITER_DIRTY_EN
      dirty_mark = 1'b0;
      dirty_page = 3'd0;
`endif
      dirty_m = 8'hFF;
      repeat (3) @(negedge clk);
      chk("reset_ctrl_a", 32'({busy_a, done_a, rd_a, we_a}), 0);
      chk("reset_regs_a", 32'({ra_a, rdat_a}), 0);
      chk("reset_addr_a", 32'(addr_a), 0);
      chk("reset_all_b", 32'({busy_b, done_b, rd_b, we_b, ra_b, rdat_b}), 0);
      reset = 1'b0;
      @(negedge clk);

      // Full and partial frames with varied latency, masks and stray starts
      for (int i = 0; i < 5; i++) run_frame(rows[i]);

      // Reset and start together: reset wins
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      dirty_m = 8'hFF;
      chk("rst_start_busy", 32'(busy_a), 0);
      @(negedge clk);
      chk("rst_start_busy_next", 32'(busy_a), 0);

      // Stray i2c_done while idle must not cause any activity
      wq_a.delete();
      done_cnt   = 0;
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_stray_writes", 32'(wq_a.size()), 0);
      chk("idle_stray_done", 32'(done_cnt), 0);

      // Reset during page 3 data, then a fresh frame restarts at page 0
      mark_pages(8'hFF);
      lat_lo = 1;
      lat_hi = 3;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(rd_a && addr_a >= 10'd384) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_page3", 32'(rd_a && addr_a >= 10'd384), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_ctrl", 32'({busy_a, done_a, rd_a, we_a}), 0);
      chk("midrst_regs", 32'({ra_a, rdat_a, 6'd0, addr_a}), 0);
      repeat (5) @(negedge clk);
      reset      = 1'b0;
      dirty_m    = 8'hFF;
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      chk("midrst_idle", 32'(busy_a), 0);
      run_frame('{1, 3, 8'h00, 0, 1048, 1048});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
